// File: rtl/wrr_grant_arbiter.sv
// wrr_grant_arbiter: weighted round-robin arbiter with grant hold.
// A granted requester keeps ownership for up to max(weight,1) back-to-back
// transactions (done strobes), then priority rotates past it. Dropping req
// releases ownership at once. On release the next owner is picked in the same
// cycle, so there is no idle bubble between owners.
// Optional hold-timeout watchdog: define WRR_HOLD_TIMEOUT_EN to build it.
module wrr_grant_arbiter #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req,
    input  logic [N-1:0]              done,
    input  logic [N*WEIGHT_W-1:0]     weight,
    output logic [N-1:0]              grant,
    output logic                      grant_valid,
    output logic [$clog2(N)-1:0]      grant_id,
    output logic                      timeout
);

    localparam int IDW = $clog2(N);
    localparam logic [N-1:0]        ONE_N      = N'(1);
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);
    localparam logic [WEIGHT_W-1:0] CREDIT_ZERO = WEIGHT_W'(0);
    localparam logic [IDW-1:0]      LAST_IDX   = IDW'(N - 1);
    localparam logic [IDW:0]        N_EXT      = (IDW + 1)'(N);

    // Elaboration-time parameter sanity checks.
    if (N < 2) begin : g_bad_n
        $error("wrr_grant_arbiter: N must be at least 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("wrr_grant_arbiter: MAX_HOLD must be at least 1");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_r;
    logic [IDW-1:0]       owner_r;
    logic [IDW-1:0]       ptr_r;
    logic [WEIGHT_W-1:0]  credit_r;
    logic [N-1:0]         grant_r;
    logic                 grant_valid_r;
    logic [IDW-1:0]       grant_id_r;
    logic                 timeout_r;

`ifdef WRR_HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0]    hold_r;
`endif

    logic                 done_own_s;
    logic                 req_own_s;
    logic                 release_s;
    logic                 expire_s;
    logic [IDW-1:0]       next_ptr_s;
    logic [IDW-1:0]       start_s;
    logic                 found_s;
    logic [IDW-1:0]       win_s;
    logic [IDW:0]         pos_s;
    logic [WEIGHT_W-1:0]  wsel_s;
    logic [WEIGHT_W-1:0]  load_credit_s;

    // Decide whether the current owner gives up the resource this cycle.
    always_comb begin
        done_own_s = done[owner_r];
        req_own_s  = req[owner_r];
        release_s  = 1'b0;
        expire_s   = 1'b0;
        if (state_r == BUSY) begin
            if (done_own_s) begin
                // Credit 1 means this done brings it to zero.
                if ((credit_r == CREDIT_ONE) || !req_own_s) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end else if (!req_own_s) begin
                release_s = 1'b1;
            end else begin
`ifdef WRR_HOLD_TIMEOUT_EN
                if (hold_r == HOLD_LAST) begin
                    release_s = 1'b1;
                    expire_s  = 1'b1;
                end else begin
                    release_s = 1'b0;
                    expire_s  = 1'b0;
                end
`else
                release_s = 1'b0;
`endif
            end
        end else begin
            release_s = 1'b0;
        end
    end

    // Pick the scan origin: after a release the old owner is scanned last.
    always_comb begin
        if (owner_r == LAST_IDX) begin
            next_ptr_s = {IDW{1'b0}};
        end else begin
            next_ptr_s = owner_r + IDW'(1);
        end
        if (state_r == BUSY) begin
            start_s = next_ptr_s;
        end else begin
            start_s = ptr_r;
        end
    end

    // Rotating priority scan: first set req bit from start_s, modulo N.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDW{1'b0}};
        pos_s   = {(IDW + 1){1'b0}};
        for (int i = 0; i < N; i++) begin
            pos_s = {1'b0, start_s} + (IDW + 1)'(i);
            if (pos_s >= N_EXT) begin
                pos_s = pos_s - N_EXT;
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[pos_s[IDW-1:0]]) begin
                found_s = 1'b1;
                win_s   = pos_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Credit to load for the winner; a zero weight counts as one.
    always_comb begin
        wsel_s = CREDIT_ZERO;
        for (int i = 0; i < N; i++) begin
            if (win_s == IDW'(i)) begin
                wsel_s = weight[i*WEIGHT_W +: WEIGHT_W];
            end else begin
                wsel_s = wsel_s;
            end
        end
        if (wsel_s == CREDIT_ZERO) begin
            load_credit_s = CREDIT_ONE;
        end else begin
            load_credit_s = wsel_s;
        end
    end

    // Arbiter state, ownership bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            owner_r       <= {IDW{1'b0}};
            ptr_r         <= {IDW{1'b0}};
            credit_r      <= CREDIT_ZERO;
            grant_r       <= {N{1'b0}};
            grant_valid_r <= 1'b0;
            grant_id_r    <= {IDW{1'b0}};
            timeout_r     <= 1'b0;
`ifdef WRR_HOLD_TIMEOUT_EN
            hold_r        <= {HOLD_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    timeout_r <= 1'b0;
                    if (found_s) begin
                        state_r       <= BUSY;
                        owner_r       <= win_s;
                        credit_r      <= load_credit_s;
                        grant_r       <= ONE_N << win_s;
                        grant_valid_r <= 1'b1;
                        grant_id_r    <= win_s;
`ifdef WRR_HOLD_TIMEOUT_EN
                        hold_r        <= {HOLD_W{1'b0}};
`endif
                    end
                end
                BUSY: begin
                    if (release_s) begin
                        ptr_r     <= next_ptr_s;
                        timeout_r <= expire_s;
                        if (found_s) begin
                            owner_r       <= win_s;
                            credit_r      <= load_credit_s;
                            grant_r       <= ONE_N << win_s;
                            grant_valid_r <= 1'b1;
                            grant_id_r    <= win_s;
                        end else begin
                            state_r       <= IDLE;
                            credit_r      <= CREDIT_ZERO;
                            grant_r       <= {N{1'b0}};
                            grant_valid_r <= 1'b0;
                        end
`ifdef WRR_HOLD_TIMEOUT_EN
                        hold_r <= {HOLD_W{1'b0}};
`endif
                    end else begin
                        timeout_r <= 1'b0;
                        if (done_own_s) begin
                            credit_r <= credit_r - CREDIT_ONE;
                        end
`ifdef WRR_HOLD_TIMEOUT_EN
                        if (done_own_s) begin
                            hold_r <= {HOLD_W{1'b0}};
                        end else begin
                            hold_r <= hold_r + HOLD_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    grant_r       <= {N{1'b0}};
                    grant_valid_r <= 1'b0;
                    timeout_r     <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign timeout     = timeout_r;

endmodule
